// File: rtl/dm_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dm_arbiter_pkg
// Shared definitions for the two-port data-memory arbiter and the memory it
// fronts.
//   DM_AW / DM_DW   : default word-address and data widths
//   DM_LOCK_MAX     : default lock timeout in cycles
//   state_t         : arbiter FSM encoding (ST_ARB, ST_LOCK0, ST_LOCK1)
// -----------------------------------------------------------------------------
package dm_arbiter_pkg;

    localparam int DM_AW       = 10;
    localparam int DM_DW       = 32;
    localparam int DM_LOCK_MAX = 16;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

endpackage

// File: rtl/dm_arbiter_rr.sv
// -----------------------------------------------------------------------------
// dm_arbiter_rr
// Pure-combinational grant picker for the two-port memory arbiter.
// Ports:
//   req0, req1   in   access requests
//   rr           in   round-robin pointer (port that wins a tie in ST_ARB)
//   state        in   arbiter FSM state
//   gnt0, gnt1   out  one-hot-or-zero grants
// -----------------------------------------------------------------------------
module dm_arbiter_rr
    import dm_arbiter_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  logic   rr,
    input  state_t state,
    output logic   gnt0,
    output logic   gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            // The lock owner is the only candidate; the peer simply stalls.
            ST_LOCK0: gnt0 = req0;
            ST_LOCK1: gnt1 = req1;
            default: begin
                // Port 0 wins when alone, or on a tie when the pointer says 0.
                if (req0 && (!req1 || !rr)) begin
                    gnt0 = 1'b1;
                end else if (req1) begin
                    gnt1 = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Two-requester arbiter in front of one single-port data memory (combinational
// read, write on posedge clk). Round-robin grant, optional ownership lock for
// atomic read-modify-write with a LOCK_MAX-cycle timeout, read data registered
// and returned one cycle after the grant.
//
// Ports (N = 0, 1):
//   clk, rst                 clock, synchronous active-high reset
//   reqN, weN, lockN         request, write enable, keep-ownership request
//   addrN, wdataN            word address, write data
//   gntN                     access accepted this cycle (combinational)
//   rvalidN, rdataN          registered read return (one-cycle pulse / held)
//   mem_addr, mem_din        address and write data to the memory
//   mem_we                   memory write strobe
//   mem_dout                 memory combinational read data
//   acc_cnt0, acc_cnt1       granted accesses per port   (DM_ARBITER_STATS_EN)
//   stall_cnt                cycles with any stalled req (DM_ARBITER_STATS_EN)
//
// Build option: define DM_ARBITER_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int AW       = DM_AW,
    parameter int DW       = DM_DW,
    parameter int LOCK_MAX = DM_LOCK_MAX
)
(
    input  logic          clk,
    input  logic          rst,

    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,

    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout
`ifdef DM_ARBITER_STATS_EN
    ,
    output logic [31:0]   acc_cnt0,
    output logic [31:0]   acc_cnt1,
    output logic [31:0]   stall_cnt
`endif
);

    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 1);

    state_t        state_q, state_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic          pick_gnt0, pick_gnt1;
    logic          rd0, rd1;

    dm_arbiter_rr u_rr (
        .req0  (req0),
        .req1  (req1),
        .rr    (rr_q),
        .state (state_q),
        .gnt0  (pick_gnt0),
        .gnt1  (pick_gnt1)
    );

    // Nothing is accepted while reset is held, so a write presented during
    // reset can never reach the memory.
    assign gnt0 = pick_gnt0 & ~rst;
    assign gnt1 = pick_gnt1 & ~rst;

    // Port 0 is the idle default for the memory mux so the address/data lines
    // only move when port 1 actually owns the cycle.
    assign mem_addr = gnt1 ? addr1  : addr0;
    assign mem_din  = gnt1 ? wdata1 : wdata0;
    assign mem_we   = (gnt0 & we0) | (gnt1 & we1);

    assign rd0 = gnt0 & ~we0;
    assign rd1 = gnt1 & ~we1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ST_LOCK0: begin
                lock_cnt_d = lock_cnt_q + CW'(1);
                if (gnt0 && !lock0) begin
                    state_d = ST_ARB;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    // Forced release hands the next tie to the starved peer.
                    state_d = ST_ARB;
                    rr_d    = 1'b1;
                end
            end
            ST_LOCK1: begin
                lock_cnt_d = lock_cnt_q + CW'(1);
                if (gnt1 && !lock1) begin
                    state_d = ST_ARB;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d = ST_ARB;
                    rr_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_ARB;
                if (gnt0) begin
                    rr_d = 1'b1;
                    if (lock0) begin
                        state_d    = ST_LOCK0;
                        lock_cnt_d = '0;
                    end
                end else if (gnt1) begin
                    rr_d = 1'b0;
                    if (lock1) begin
                        state_d    = ST_LOCK1;
                        lock_cnt_d = '0;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and read-return registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARB;
            rr_q       <= 1'b0;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rd0;
            rvalid1_q  <= rd1;
            if (rd0) begin
                rdata0_q <= mem_dout;
            end
            if (rd1) begin
                rdata1_q <= mem_dout;
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

`ifdef DM_ARBITER_STATS_EN
    logic [31:0] acc_cnt0_q, acc_cnt1_q, stall_cnt_q;
    logic        stall_any;

    // A cycle counts once even when both ports are waiting.
    assign stall_any = (req0 & ~gnt0) | (req1 & ~gnt1);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt0_q  <= '0;
            acc_cnt1_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (gnt0) begin
                acc_cnt0_q <= acc_cnt0_q + 32'd1;
            end
            if (gnt1) begin
                acc_cnt1_q <= acc_cnt1_q + 32'd1;
            end
            if (stall_any) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign acc_cnt0  = acc_cnt0_q;
    assign acc_cnt1  = acc_cnt1_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Self-checking bench for dm_arbiter (built with LOCK_MAX = 4). Directed
// vector table for the reset / contention / lock / timeout / reset-mid-lock
// scenarios, then randomized traffic, all cross-checked against a
// transaction-level reference model and a shadow copy of memory.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

    localparam int AW       = 10;
    localparam int DW       = 32;
    localparam int LOCK_MAX = 4;
    localparam int NROWS    = 28;

    logic          clk;
    logic          rst;
    logic          req0, we0, lock0, req1, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic          mem_we;
`ifdef DM_ARBITER_STATS_EN
    logic [31:0]   acc_cnt0, acc_cnt1, stall_cnt;
`endif

    dm_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .we0      (we0),
        .lock0    (lock0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .gnt0     (gnt0),
        .rvalid0  (rvalid0),
        .rdata0   (rdata0),
        .req1     (req1),
        .we1      (we1),
        .lock1    (lock1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .gnt1     (gnt1),
        .rvalid1  (rvalid1),
        .rdata1   (rdata1),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
`ifdef DM_ARBITER_STATS_EN
        ,
        .acc_cnt0 (acc_cnt0),
        .acc_cnt1 (acc_cnt1),
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The data memory the arbiter fronts.
    logic [DW-1:0] tb_mem [0:(1<<AW)-1];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_din;
    assign mem_dout = tb_mem[mem_addr];

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: who owns the memory, whose turn it is on a tie,
    // when the current ownership began, and what each port should see.
    // ------------------------------------------------------------------
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            owner;      // -1: nobody holds a lock
    int            turn;       // port preferred on a tie
    int            own_since;  // first cycle spent under the current lock
    int            cyc;
    int            m_g;        // port the model grants this cycle, -1 none
    logic          m_rv0, m_rv1;
    logic [DW-1:0] m_rd0, m_rd1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_grant();
        m_g = -1;
        if (!rst) begin
            if (owner == 0)      m_g = req0 ? 0 : -1;
            else if (owner == 1) m_g = req1 ? 1 : -1;
            else if (req0 && req1) m_g = turn;
            else if (req0) m_g = 0;
            else if (req1) m_g = 1;
        end
    endtask

    task automatic model_clock();
        logic keep;
        if (rst) begin
            owner = -1; turn = 0;
            m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
        end else begin
            m_rv0 = (m_g == 0) && !we0;
            m_rv1 = (m_g == 1) && !we1;
            if (m_rv0) m_rd0 = ref_mem[addr0];
            if (m_rv1) m_rd1 = ref_mem[addr1];
            if (m_g == 0 && we0) ref_mem[addr0] = wdata0;
            if (m_g == 1 && we1) ref_mem[addr1] = wdata1;
            if (owner < 0) begin
                if (m_g >= 0) begin
                    turn = 1 - m_g;
                    keep = (m_g == 0) ? lock0 : lock1;
                    if (keep) begin owner = m_g; own_since = cyc + 1; end
                end
            end else begin
                keep = (owner == 0) ? lock0 : lock1;
                if (m_g == owner && !keep) begin
                    owner = -1;
                end else if (cyc - own_since == LOCK_MAX - 1) begin
                    turn  = 1 - owner;
                    owner = -1;
                end
            end
        end
        cyc++;
    endtask

    task automatic check_model(input string tag);
        logic exp_we;
        chk({tag, " gnt0"}, 32'(gnt0), 32'(m_g == 0));
        chk({tag, " gnt1"}, 32'(gnt1), 32'(m_g == 1));
        exp_we = (m_g == 0 && we0) || (m_g == 1 && we1);
        chk({tag, " mem_we"}, 32'(mem_we), 32'(exp_we));
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'((m_g == 1) ? addr1 : addr0));
        if (exp_we) chk({tag, " mem_din"}, mem_din, (m_g == 1) ? wdata1 : wdata0);
        chk({tag, " rvalid0"}, 32'(rvalid0), 32'(m_rv0));
        chk({tag, " rvalid1"}, 32'(rvalid1), 32'(m_rv1));
        chk({tag, " rdata0"}, rdata0, m_rd0);
        chk({tag, " rdata1"}, rdata1, m_rd1);
    endtask

    // One cycle: inputs already applied after a negedge.
    task automatic tick(input string tag);
        #1;
        model_grant();
        check_model(tag);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic drive(input logic rs,
                         input logic r0, input logic w0, input logic l0,
                         input int a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic l1,
                         input int a1, input logic [31:0] d1);
        rst = rs;
        req0 = r0; we0 = w0; lock0 = l0; addr0 = AW'(a0); wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = AW'(a1); wdata1 = d1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic          rs;
        logic          r0, w0, l0;
        int            a0;
        logic [31:0]   d0;
        logic          r1, w1, l1;
        int            a1;
        logic [31:0]   d1;
        logic          eg0, eg1, ewe, ev0, ev1;
    } vec_t;

    function automatic vec_t row(input logic rs,
                                 input logic r0, input logic w0, input logic l0,
                                 input int a0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic l1,
                                 input int a1, input logic [31:0] d1,
                                 input logic eg0, input logic eg1, input logic ewe,
                                 input logic ev0, input logic ev1);
        vec_t v;
        v.rs = rs; v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe; v.ev0 = ev0; v.ev1 = ev1;
        return v;
    endfunction

    vec_t tbl [NROWS];

    // Random-traffic requester state (held until granted).
    logic          p0_on, p0_we, p0_lk, p1_on, p1_we, p1_lk;
    logic [AW-1:0] p0_a, p1_a;
    logic [DW-1:0] p0_d, p1_d;

    initial begin
        //              rs r0 w0 l0 a0 d0            r1 w1 l1 a1 d1            g0 g1 we v0 v1
        // reset, with a write presented that must not land
        tbl[0]  = row(1, 1, 1, 0, 7, 32'hCAFE,     0, 0, 0, 0, 0,            0, 0, 0, 0, 0);
        // single read of the preloaded word
        tbl[1]  = row(0, 1, 0, 0, 5, 0,            0, 0, 0, 0, 0,            1, 0, 0, 0, 0);
        tbl[2]  = row(0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0, 1, 0);
        tbl[3]  = row(1, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0, 0, 0);
        // continuous contention: grants alternate 0,1,0,1
        tbl[4]  = row(0, 1, 1, 0, 10, 32'h100,     1, 0, 0, 11, 0,           1, 0, 1, 0, 0);
        tbl[5]  = row(0, 1, 1, 0, 10, 32'h101,     1, 0, 0, 11, 0,           0, 1, 0, 0, 0);
        tbl[6]  = row(0, 1, 1, 0, 10, 32'h101,     1, 0, 0, 12, 0,           1, 0, 1, 0, 1);
        tbl[7]  = row(0, 1, 1, 0, 10, 32'h102,     1, 0, 0, 12, 0,           0, 1, 0, 0, 0);
        tbl[8]  = row(0, 1, 1, 0, 10, 32'h102,     1, 0, 1, 3, 0,            1, 0, 1, 0, 1);
        // locked RMW by port 1 while port 0 keeps requesting
        tbl[9]  = row(0, 1, 0, 0, 20, 0,           1, 0, 1, 3, 0,            0, 1, 0, 0, 0);
        tbl[10] = row(0, 1, 0, 0, 20, 0,           1, 1, 0, 3, 32'h11,       0, 1, 1, 0, 1);
        tbl[11] = row(0, 1, 0, 0, 20, 0,           0, 0, 0, 0, 0,            1, 0, 0, 0, 0);
        tbl[12] = row(0, 1, 0, 0, 3, 0,            0, 0, 0, 0, 0,            1, 0, 0, 1, 0);
        tbl[13] = row(0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0, 1, 0);
        // lock timeout: port 0 reads locked every cycle, port 1 waits
        tbl[14] = row(0, 1, 0, 1, 30, 0,           0, 0, 0, 0, 0,            1, 0, 0, 0, 0);
        tbl[15] = row(0, 1, 0, 1, 31, 0,           1, 0, 0, 40, 0,           1, 0, 0, 1, 0);
        tbl[16] = row(0, 1, 0, 1, 32, 0,           1, 0, 0, 40, 0,           1, 0, 0, 1, 0);
        tbl[17] = row(0, 1, 0, 1, 33, 0,           1, 0, 0, 40, 0,           1, 0, 0, 1, 0);
        tbl[18] = row(0, 1, 0, 1, 34, 0,           1, 0, 0, 40, 0,           1, 0, 0, 1, 0);
        tbl[19] = row(0, 1, 0, 1, 35, 0,           1, 0, 0, 40, 0,           0, 1, 0, 1, 0);
        tbl[20] = row(0, 1, 0, 1, 35, 0,           0, 0, 0, 0, 0,            1, 0, 0, 0, 1);
        tbl[21] = row(0, 1, 0, 0, 36, 0,           1, 0, 1, 50, 0,           1, 0, 0, 1, 0);
        // reset while port 1 holds the lock with a write pending
        tbl[22] = row(0, 0, 0, 0, 0, 0,            1, 0, 1, 50, 0,           0, 1, 0, 1, 0);
        tbl[23] = row(1, 1, 0, 0, 5, 0,            1, 1, 1, 50, 32'hBAD,     0, 0, 0, 0, 1);
        tbl[24] = row(0, 1, 0, 0, 5, 0,            0, 0, 0, 0, 0,            1, 0, 0, 0, 0);
        tbl[25] = row(0, 1, 0, 0, 50, 0,           0, 0, 0, 0, 0,            1, 0, 0, 1, 0);
        tbl[26] = row(0, 1, 0, 0, 7, 0,            0, 0, 0, 0, 0,            1, 0, 0, 1, 0);
        tbl[27] = row(0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0, 1, 0);

        for (int i = 0; i < (1 << AW); i++) begin
            tb_mem[i]  <= init_val(i);
            ref_mem[i]  = init_val(i);
        end
        tb_mem[5]  <= 32'hDEAD_BEEF;
        ref_mem[5]  = 32'hDEAD_BEEF;
        owner = -1; turn = 0; own_since = 0; cyc = 0; m_g = -1;
        m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;

        // Registered outputs are unknown before the first reset edge.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        model_clock();
        @(negedge clk);

        for (int i = 0; i < NROWS; i++) begin
            drive(tbl[i].rs, tbl[i].r0, tbl[i].w0, tbl[i].l0, tbl[i].a0, tbl[i].d0,
                  tbl[i].r1, tbl[i].w1, tbl[i].l1, tbl[i].a1, tbl[i].d1);
            #1;
            chk($sformatf("row%0d gnt0", i),    32'(gnt0),    32'(tbl[i].eg0));
            chk($sformatf("row%0d gnt1", i),    32'(gnt1),    32'(tbl[i].eg1));
            chk($sformatf("row%0d mem_we", i),  32'(mem_we),  32'(tbl[i].ewe));
            chk($sformatf("row%0d rvalid0", i), 32'(rvalid0), 32'(tbl[i].ev0));
            chk($sformatf("row%0d rvalid1", i), 32'(rvalid1), 32'(tbl[i].ev1));
            if (i == 2)  chk("single read rdata0", rdata0, 32'hDEAD_BEEF);
            if (i == 13) chk("rmw readback rdata0", rdata0, 32'h0000_0011);
            if (i == 24) chk("reset clears rdata1", rdata1, 32'h0);
            tick($sformatf("row%0d", i));
            $display("row %0d: gnt0=%0b gnt1=%0b mem_we=%0b rvalid0=%0b rvalid1=%0b",
                     i, tbl[i].eg0, tbl[i].eg1, tbl[i].ewe, tbl[i].ev0, tbl[i].ev1);
        end

        chk("mem[3] after rmw",        tb_mem[3],  32'h0000_0011);
        chk("mem[10] after writes",    tb_mem[10], 32'h0000_0102);
        chk("mem[50] after reset",     tb_mem[50], init_val(50));
        chk("mem[7] write in reset",   tb_mem[7],  init_val(7));

`ifdef DM_ARBITER_STATS_EN
        // 3 port-0 grants (last one takes the lock), then port 1 stalls twice.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick("st rst");
        drive(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0); tick("st c1");
        drive(0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0); tick("st c2");
        drive(0, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0); tick("st c3");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 4, 0); tick("st c4");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 4, 0); tick("st c5");
        #1;
        chk("acc_cnt0", acc_cnt0, 32'd3);
        chk("acc_cnt1", acc_cnt1, 32'd0);
        chk("stall_cnt", stall_cnt, 32'd2);
        $display("stats: acc_cnt0=%0d acc_cnt1=%0d stall_cnt=%0d", acc_cnt0, acc_cnt1, stall_cnt);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick("st rst2");
        #1;
        chk("acc_cnt0 cleared", acc_cnt0, 32'd0);
        chk("stall_cnt cleared", stall_cnt, 32'd0);
`endif

        // ------------------------------------------------------------------
        // Randomized traffic: each port holds a request until it is granted.
        // ------------------------------------------------------------------
        p0_on = 1'b0; p1_on = 1'b0;
        p0_we = 1'b0; p0_lk = 1'b0; p0_a = '0; p0_d = '0;
        p1_we = 1'b0; p1_lk = 1'b0; p1_a = '0; p1_d = '0;
        for (int c = 0; c < 600; c++) begin
            if (!p0_on && ($urandom_range(0, 2) != 0)) begin
                p0_on = 1'b1; p0_we = 1'($urandom_range(0, 1));
                p0_lk = ($urandom_range(0, 9) < 3); p0_a = AW'($urandom_range(0, 15));
                p0_d  = $urandom;
            end
            if (!p1_on && ($urandom_range(0, 2) != 0)) begin
                p1_on = 1'b1; p1_we = 1'($urandom_range(0, 1));
                p1_lk = ($urandom_range(0, 9) < 3); p1_a = AW'($urandom_range(0, 15));
                p1_d  = $urandom;
            end
            drive(($urandom_range(0, 49) == 0),
                  p0_on, p0_we, p0_lk, int'(p0_a), p0_d,
                  p1_on, p1_we, p1_lk, int'(p1_a), p1_d);
            tick($sformatf("rand%0d", c));
            $display("rand %0d: rst=%0b req0=%0b req1=%0b granted=%0d", c, rst, req0, req1, m_g);
            if (rst) begin
                p0_on = 1'b0; p1_on = 1'b0;
            end else begin
                if (m_g == 0) p0_on = 1'b0;
                if (m_g == 1) p1_on = 1'b0;
            end
        end

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("final mem[%0d]", i), tb_mem[i], ref_mem[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter sharing one single-port data memory (word-addressed, combinational read, write on posedge clk).
- Port 0 is the CPU load/store path; port 1 is a secondary master (loader/DMA/debug).
- Round-robin grant with an optional ownership lock for atomic read-modify-write sequences, bounded by a lock timeout.
- Read data is registered and returned one cycle after grant.

Parameters:
- AW, 10, word-address width (1024 words).
- DW, 32, data width.
- LOCK_MAX, 16, maximum consecutive cycles one port may hold the lock before forced release.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  port 0 access request.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- lock0  in  1  port 0 requests to keep ownership after this access.
- addr0  in  AW  port 0 word address.
- wdata0  in  DW  port 0 write data.
- gnt0  out  1  port 0 access accepted this cycle (combinational).
- rvalid0  out  1  port 0 read data valid (registered).
- rdata0  out  DW  port 0 read data (registered).
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_addr  out  AW  address to memory.
- mem_din  out  DW  write data to memory.
- mem_we  out  1  memory write strobe.
- mem_dout  in  DW  memory combinational read data.

Behaviour:
- Handshake: an access completes in the cycle where reqN && gntN. Requester holds req/we/addr/wdata/lock stable until granted. gnt is combinational from req, state and rr.
- At most one gnt per cycle. mem_addr/mem_din are muxed from the granted port; mem_we = granted && weN.
- With no grant: mem_we = 0 and mem_addr/mem_din come from port 0, to avoid muxing glitches.
- Read latency: granted read in cycle N gives rvalidN = 1 and rdataN = mem_dout(N) captured at end of N, visible in N+1 for exactly one cycle. rdataN holds its value otherwise.
- Writes produce no rvalid.
- FSM states: ARB, LOCK0, LOCK1.
- ARB:
  - Only one req: grant it.
  - Both req: grant port rr; after every grant in ARB, rr <= other port.
  - Granted access with lockN = 1: go to LOCKN, lock_cnt <= 0.
- LOCKN:
  - Only port N can be granted; the other port is stalled.
  - Each cycle in LOCKN: lock_cnt++.
  - Granted access with lockN = 0: back to ARB.
  - reqN = 0: stay, port N keeps ownership.
  - lock_cnt reaches LOCK_MAX-1 without release: forced to ARB next cycle and rr <= other port, so a locked port cannot starve its peer. The access granted in that final cycle still completes normally.
- Simultaneous events:
  - Release and other-port request in the same cycle: the other port is served from the next cycle.
  - Back-to-back grants to the same port are legal. Consecutive reads give consecutive rvalid pulses.
- Reset (synchronous, rst = 1 at posedge):
  - state = ARB, rr = 0, lock_cnt = 0, rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0.
  - While rst = 1: gnt0 = gnt1 = 0 and mem_we = 0. A write presented during reset is never committed.
  - Reset mid-lock abandons the lock. A pending rvalid from the cycle before reset is suppressed.

Optional Feature:
- Macro: DM_ARBITER_STATS_EN.
- Defined: adds outputs acc_cnt0, acc_cnt1 (32 bits each), counting granted accesses per port, and stall_cnt (32 bits), counting cycles with reqN && !gntN on either port (increment 1 per cycle even if both stall).
  - Counters wrap at 2^32 and are cleared by rst.
  - Read-only; no effect on arbitration.
- Not defined: counter ports and logic absent; interface identical to the base list.

Decomposition:
- Shared package dm_arbiter_pkg:
  - state encoding constants ST_ARB = 2'd0, ST_LOCK0 = 2'd1, ST_LOCK1 = 2'd2.
  - default AW/DW values, shared with the data memory.
- Sub-module dm_arbiter_rr: the pure-combinational grant picker (req0, req1, rr, state -> gnt0, gnt1). Everything else stays in the top.

Test Plan:
- Reset then single read: preload mem[5] = 32'hDEADBEEF; req0 read addr 5 -> gnt0 same cycle, rvalid0 = 1 and rdata0 = DEADBEEF next cycle, rvalid1 = 0.
- Contention: req0 and req1 both asserted continuously for 4 cycles after reset -> grants alternate 0,1,0,1; mem_we only on write grants.
- Lock RMW: port 1 reads addr 3 with lock1 = 1, then writes addr 3 = 32'h0000_0011 with lock1 = 0 while port 0 requests throughout -> gnt0 held 0 during both cycles; port 0 granted the cycle after the write; mem[3] = 11.
- Lock timeout (LOCK_MAX = 4): port 0 issues locked reads every cycle while port 1 requests -> port 1 granted no later than the 5th cycle after lock entry.
- Reset mid-lock: assert rst for 1 cycle while in LOCK1 with a write pending -> memory unchanged, state ARB, rvalid cleared, port 0 granted immediately after.
- DM_ARBITER_STATS_EN: 3 port-0 grants plus 2 stalled cycles -> acc_cnt0 = 3, stall_cnt = 2; rst clears both to 0.
